// File: rtl/fme_half_sched.sv
// Half-pel motion-estimation job scheduler.
// Two requesters share one half-pel interpolation engine through a
// round-robin arbiter. The FSM runs one job at a time: it launches the
// engine, waits for its result with a timeout, then holds the response
// until the consumer takes it.
module fme_half_sched #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_ind,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_ind,
  output logic              req1_ready,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_ind,
  input  logic              eng_done,
  input  logic [71:0]       eng_half,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [ADDR_W-1:0] rsp_ind,
  output logic [71:0]       rsp_half,
  output logic              rsp_err,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            ptr;        // 1: requester 1 has priority
  logic            grant_vld;
  logic            grant_id;
  logic            accept;
  logic [TW-1:0]   timer;
  logic            first_wait;
  logic            done_ok;
  logic            tmo;

  // Round-robin pick: the pointer names the favoured requester.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (ptr) grant_id = req1_valid ? 1'b1 : 1'b0;
    else     grant_id = req0_valid ? 1'b0 : 1'b1;
  end

  // A done seen in the first WAIT cycle may belong to the previous job.
  assign first_wait = (timer == '0);
  assign done_ok    = (state == ST_WAIT) && !first_wait && eng_done;
  assign tmo        = (state == ST_WAIT) && (timer == TW'(TIMEOUT - 1)) && !done_ok;
  assign accept     = rst && (state == ST_IDLE) && grant_vld;

  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign rsp_ind   = eng_ind;

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    eng_start  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt  = ST_LAUNCH;
          req0_ready = !grant_id;
          req1_ready = grant_id;
        end
      end
      ST_LAUNCH: begin
        eng_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_ok || tmo) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples values from before the clock edge.
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Job context, timer, captured result and error counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= 1'b0;
      eng_ind  <= '0;
      rsp_id   <= 1'b0;
      timer    <= '0;
      rsp_half <= '0;
      rsp_err  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (accept) begin
        ptr     <= !grant_id;
        rsp_id  <= grant_id;
        eng_ind <= grant_id ? req1_ind : req0_ind;
      end
      if (state == ST_LAUNCH) timer <= '0;
      if (state == ST_WAIT)   timer <= timer + TW'(1);
      if (done_ok) begin
        rsp_half <= eng_half;
        rsp_err  <= 1'b0;
      end else if (tmo) begin
        rsp_half <= '0;
        rsp_err  <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fme_half_sched.sv
// Self-checking bench for fme_half_sched. A transaction-level model
// predicts the grant, the response cycle, the captured data and the
// error count for each job; the engine is emulated by the bench.
module tb_fme_half_sched;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req0_valid = 1'b0;
  logic [ADDR_W-1:0] req0_ind = '0;
  logic              req0_ready;
  logic              req1_valid = 1'b0;
  logic [ADDR_W-1:0] req1_ind = '0;
  logic              req1_ready;
  logic              eng_start;
  logic [ADDR_W-1:0] eng_ind;
  logic              eng_done = 1'b0;
  logic [71:0]       eng_half = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_id;
  logic [ADDR_W-1:0] rsp_ind;
  logic [71:0]       rsp_half;
  logic              rsp_err;
  logic              busy;
  logic [7:0]        err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: last granted requester and expected error count.
  bit last_grant = 1'b1;
  int model_err_cnt = 0;

  fme_half_sched #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ind   (req0_ind),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_ind   (req1_ind),
    .req1_ready (req1_ready),
    .eng_start  (eng_start),
    .eng_ind    (eng_ind),
    .eng_done   (eng_done),
    .eng_half   (eng_half),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_ind    (rsp_ind),
    .rsp_half   (rsp_half),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion, want completion before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [102:0] all_outputs();
    return {eng_start, eng_ind, req0_ready, req1_ready, rsp_valid, rsp_id,
            rsp_ind, rsp_half, rsp_err, busy, err_cnt};
  endfunction

  function automatic logic [4:0] ctl();
    return {rsp_valid, eng_start, req0_ready, req1_ready, busy};
  endfunction

  task automatic model_reset();
    last_grant    = 1'b1;
    model_err_cnt = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b0; eng_done = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One complete job. done_dly: cycles after the eng_start cycle at which
  // the engine raises done (0 = never). stale: done still high from the
  // previous job during the launch and first wait cycle.
  task automatic run_job(input bit v0, input bit v1,
                         input logic [ADDR_W-1:0] i0, input logic [ADDR_W-1:0] i1,
                         input logic [71:0] half, input int done_dly,
                         input bit stale, input int hold, input string tag);
    bit              exp_id;
    logic [ADDR_W-1:0] exp_ind;
    logic [71:0]     exp_half;
    bit              exp_err;
    int              resp_k;
    logic [4:0]      ctl_exp;
    logic [17:0]     rsp_exp;
    logic [17:0]     rsp_got;

    // Reference model: round-robin grant, timeout window, capture.
    exp_id     = (v0 && v1) ? !last_grant : v1;
    last_grant = exp_id;
    exp_ind    = exp_id ? i1 : i0;
    if (done_dly == 0 || done_dly > TIMEOUT) begin
      exp_err  = 1'b1;
      exp_half = '0;
      resp_k   = TIMEOUT + 1;
      if (model_err_cnt < 255) model_err_cnt++;
    end else begin
      exp_err  = 1'b0;
      exp_half = half;
      resp_k   = ((done_dly < 2) ? 2 : done_dly) + 1;
    end
    rsp_exp = {exp_id, exp_err, exp_ind, 8'(model_err_cnt)};

    // Acceptance cycle.
    @(negedge clk);
    req0_valid = v0; req1_valid = v1; req0_ind = i0; req1_ind = i1;
    rsp_ready = 1'b0; eng_done = stale;
    #1;
    ctl_exp = {1'b0, 1'b0, !exp_id, exp_id, 1'b0};
    n_checks++;
    if (ctl() !== ctl_exp) begin
      n_fail++;
      $display("FAIL %s accept {rv,start,r0,r1,busy}: got %b want %b", tag, ctl(), ctl_exp);
    end

    // Launch cycle; request indices change after acceptance.
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_ind = ADDR_W'($urandom); req1_ind = ADDR_W'($urandom);
    #1;
    n_checks++;
    if (ctl() !== 5'b01001 || eng_ind !== exp_ind) begin
      n_fail++;
      $display("FAIL %s launch ctl/eng_ind: got %b/%h want 01001/%h", tag, ctl(), eng_ind, exp_ind);
    end

    // Wait cycles up to and including the capture or timeout cycle.
    for (int k = 1; k < resp_k; k++) begin
      @(negedge clk);
      eng_done   = (k == 1) ? stale : (done_dly != 0 && k >= done_dly);
      eng_half   = (eng_done && k >= 2) ? half : {8'($urandom), 32'($urandom), 32'($urandom)};
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      #1;
      n_checks++;
      if (ctl() !== 5'b00001 || eng_ind !== exp_ind) begin
        n_fail++;
        $display("FAIL %s wait k=%0d ctl/eng_ind: got %b/%h want 00001/%h", tag, k, ctl(), eng_ind, exp_ind);
      end
    end

    // Response held for hold cycles, then accepted in the last pass.
    for (int h = 0; h <= hold + 1; h++) begin
      @(negedge clk);
      eng_done  = 1'b0;
      rsp_ready = (h == hold + 1);
      if (h == hold + 1) begin
        req0_valid = 1'b1; req1_valid = 1'b1;
      end else begin
        req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      end
      #1;
      rsp_got = {rsp_id, rsp_err, rsp_ind, err_cnt};
      n_checks++;
      if (ctl() !== 5'b10001 || rsp_got !== rsp_exp || rsp_half !== exp_half) begin
        n_fail++;
        $display("FAIL %s resp h=%0d ctl {id,err,ind,cnt} half: got %b %h %h want 10001 %h %h",
                 tag, h, ctl(), rsp_got, rsp_half, rsp_exp, exp_half);
      end
    end

    // First IDLE cycle after the handshake.
    @(negedge clk);
    rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    n_checks++;
    if (ctl() !== 5'b00000) begin
      n_fail++;
      $display("FAIL %s idle after handshake ctl: got %b want 00000", tag, ctl());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; eng_done = 1'b1;
    rsp_ready = 1'b1; req0_ind = 8'hA5; req1_ind = 8'h5A;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (all_outputs() !== '0) begin
        n_fail++;
        $display("FAIL reset outputs: got %h want 0", all_outputs());
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; eng_done = 1'b0; rsp_ready = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    run_job(1'b1, 1'b0, 8'h55, 8'h00, 72'h010203040506070809, 5, 1'b0, 0, "single");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int j = 0; j < 4; j++)
      run_job(1'b1, 1'b1, ADDR_W'($urandom), ADDR_W'($urandom),
              {8'($urandom), 32'($urandom), 32'($urandom)},
              $urandom_range(2, 10), 1'b0, 0, "rr");
  endtask

  task automatic test_boundaries();
    run_job(1'b0, 1'b1, 8'h01, 8'h02, 72'hFFEEDDCCBBAA998877, 2, 1'b0, 0, "done_min");
    run_job(1'b1, 1'b0, 8'h03, 8'h04, 72'h112233445566778899, TIMEOUT, 1'b0, 0, "done_at_limit");
    run_job(1'b1, 1'b1, 8'h05, 8'h06, 72'h0A0B0C0D0E0F101112, TIMEOUT + 1, 1'b0, 0, "done_late");
  endtask

  task automatic test_stale_done();
    run_job(1'b1, 1'b0, 8'h10, 8'h20, 72'hDEADBEEFCAFEF00D12, 6, 1'b1, 0, "stale");
    run_job(1'b0, 1'b1, 8'h30, 8'h40, 72'h123456789ABCDEF012, 1, 1'b1, 0, "stale_held");
  endtask

  task automatic test_backpressure();
    run_job(1'b1, 1'b1, 8'h77, 8'h88, 72'h0F0E0D0C0B0A090807, 4, 1'b0, 10, "backpressure");
  endtask

  task automatic test_random();
    for (int j = 0; j < 24; j++) begin
      int  sel;
      int  dly;
      sel = $urandom_range(1, 3);
      dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 70);
      run_job(sel[0], sel[1], ADDR_W'($urandom), ADDR_W'($urandom),
              {8'($urandom), 32'($urandom), 32'($urandom)},
              dly, 1'($urandom), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_timeout_saturate();
    run_job(1'b1, 1'b0, 8'hC3, 8'h3C, 72'h0, 0, 1'b0, 0, "timeout");
    for (int j = 0; j < 256; j++)
      run_job(1'($urandom), 1'b1, ADDR_W'($urandom), ADDR_W'($urandom),
              {8'($urandom), 32'($urandom), 32'($urandom)},
              0, 1'($urandom), 0, "err_sat");
  endtask

  task automatic test_reset_mid_job();
    @(negedge clk);
    req0_valid = 1'b1; req0_ind = 8'h9C;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; eng_done = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (all_outputs() !== '0) begin
      n_fail++;
      $display("FAIL mid-job reset outputs: got %h want 0", all_outputs());
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (all_outputs() !== '0) begin
        n_fail++;
        $display("FAIL held reset outputs: got %h want 0", all_outputs());
      end
    end
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; eng_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (ctl() !== 5'b00000) begin
        n_fail++;
        $display("FAIL post-reset no response ctl: got %b want 00000", ctl());
      end
    end
    run_job(1'b0, 1'b1, 8'h00, 8'hE7, 72'hABCDEF0123456789AB, 7, 1'b0, 0, "after_reset_req1");
    run_job(1'b0, 1'b1, 8'h00, 8'h18, 72'h0123456789ABCDEF01, 3, 1'b0, 0, "after_reset_req1b");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_boundaries();
    test_stale_done();
    test_backpressure();
    test_random();
    test_timeout_saturate();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fme_half_sched.md
FME_HALF_SCHED -- requirements
Module: fme_half_sched

Interface
REQ-001 Parameter: ADDR_W, default 8, width of the integer-pixel centre index.
REQ-002 Parameter: TIMEOUT, default 64, maximum number of WAIT cycles before a job is aborted.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  in  1  requester 0/1 has a job.
REQ-006 req0_ind / req1_ind  in  ADDR_W  requester 0/1 centre integer-pixel index.
REQ-007 req0_ready / req1_ready  out  1  requester 0/1 job accepted this cycle.
REQ-008 eng_start  out  1  single-cycle start pulse to the half-pel interpolation engine.
REQ-009 eng_ind  out  ADDR_W  centre index driven to the engine; held stable from LAUNCH through the end of WAIT.
REQ-010 eng_done  in  1  engine result valid; level signal, cleared by the engine within one cycle of eng_start.
REQ-011 eng_half  in  72  nine 8-bit half-pel results; byte k is eng_half[8k+7:8k].
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  consumer accepts the response.
REQ-014 rsp_id  out  1  requester that owns the response.
REQ-015 rsp_ind  out  ADDR_W  centre index of the job.
REQ-016 rsp_half  out  72  captured results.
REQ-017 rsp_err  out  1  job timed out.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 err_cnt  out  8  count of timed-out jobs, saturating at 255.

Function
REQ-020 The FSM SHALL have the states IDLE, LAUNCH, WAIT and RESP, encoded in 2 bits.
REQ-021 IDLE: if any reqX_valid is high, the grant SHALL go to the requester selected by round-robin, reqX_ready SHALL be driven combinationally high for the granted requester only, reqX_ind and the id SHALL be latched, and the next state SHALL be LAUNCH.
REQ-022 Round-robin: the last-granted requester SHALL have lowest priority; with both requests valid, grants SHALL alternate; the priority pointer SHALL reset to requester 0 having highest priority.
REQ-023 reqX_ready SHALL be low in every state other than IDLE.
REQ-024 LAUNCH: eng_start SHALL be 1 for exactly one cycle, the timer SHALL be cleared to 0, and the next state SHALL be WAIT.
REQ-025 WAIT: the timer SHALL increment every cycle, and eng_done SHALL be ignored in the first WAIT cycle (stale done from the previous job).
REQ-026 WAIT, from the second cycle: on eng_done=1, eng_half SHALL be captured into rsp_half, rsp_err SHALL be set to 0, and the next state SHALL be RESP.
REQ-027 WAIT: if the timer equals TIMEOUT-1 and eng_done=0, rsp_half SHALL be set to 0, rsp_err to 1, err_cnt SHALL increment (saturating), and the next state SHALL be RESP.
REQ-028 If eng_done arrives in the same cycle the timer reaches TIMEOUT-1, done SHALL win and no error SHALL be counted.
REQ-029 RESP: rsp_valid SHALL be 1, and rsp_id, rsp_ind, rsp_half and rsp_err SHALL be held stable until the cycle with rsp_ready=1, after which the FSM SHALL enter IDLE and rsp_valid SHALL be 0 in the following cycle.
REQ-030 A new request SHALL NOT be accepted in the RESP-to-IDLE transition cycle; the earliest acceptance is the first IDLE cycle.
REQ-031 Latency: a request accepted in cycle T SHALL give eng_start in cycle T+1, and eng_done first sampled high in cycle D (D ≥ T+3) SHALL give rsp_valid in cycle D+1.
REQ-032 eng_start SHALL never be asserted while a job is outstanding, so at most one job is in flight.
REQ-033 A change in reqX_ind after acceptance SHALL NOT affect eng_ind or rsp_ind.

Reset
REQ-034 While rst=0, the FSM SHALL be in IDLE, the pointer SHALL favour requester 0, and all outputs SHALL be 0: eng_start, eng_ind, reqX_ready, rsp_valid, rsp_id, rsp_ind, rsp_half, rsp_err, busy and err_cnt.
REQ-035 Reset asserted mid-job (LAUNCH/WAIT/RESP) SHALL abort the job immediately with no response, and after release the first job SHALL be a fresh arbitration.

Verification
REQ-036 Single job: req0_ind=0x55, engine returns done 5 cycles after start with eng_half=0x0102..09 -> eng_start 1 cycle after accept, eng_ind=0x55, rsp_valid with rsp_id=0, rsp_ind=0x55, rsp_half=0x010203040506070809, rsp_err=0.
REQ-037 Both requesters held valid for 4 jobs -> grant order 0,1,0,1, and each response's rsp_id matches its grant.
REQ-038 Engine never raises done, TIMEOUT=64 -> rsp_valid with rsp_err=1 and rsp_half=0 after 64 WAIT cycles, err_cnt=1; 256 such jobs -> err_cnt=255.
REQ-039 eng_done held high from the previous job into the first WAIT cycle -> ignored, and capture occurs only on a later done.
REQ-040 rsp_ready held low for 10 cycles -> rsp_* stable and reqX_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-041 rst pulsed low during WAIT -> all outputs 0, no response emitted, and after release req1-only traffic is granted normally.
